// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt sequencer: arbitrates RST/NMI/IRQ/BRK at instruction boundaries
// and steps the seven-cycle push/vector-fetch sequence with registered control outputs.
module interrupt_sequencer (
  input  logic       PHI0,
  input  logic       _RES,
  input  logic       _NMI,
  input  logic       _IRQ,
  input  logic       i_flag,
  input  logic       rdy,
  input  logic       sync,
  input  logic       brk_op,
  output logic       busy,
  output logic       force_brk,
  output logic       pc_inc_inhibit,
  output logic       push_pch,
  output logic       push_pcl,
  output logic       push_p,
  output logic       sp_dec,
  output logic       fetch_vec_lo,
  output logic       fetch_vec_hi,
  output logic       set_i,
  output logic       b_flag,
  output logic       int_done,
  output logic [2:0] vec_adl
);

  typedef enum logic [2:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_IDLE} state_t;
  typedef enum logic [1:0] {K_RST, K_NMI, K_IRQ, K_BRK} kind_t;

  state_t     r_state;
  kind_t      r_kind;
  logic       r_reset_pend, r_nmi_pend, r_nmi_s1, r_nmi_s2;
  logic       r_busy, r_force_brk, r_pc_inc_inhibit, r_push_pch, r_push_pcl, r_push_p;
  logic       r_sp_dec, r_fetch_vec_lo, r_fetch_vec_hi, r_set_i, r_b_flag, r_int_done;
  logic [2:0] r_vec_adl;

  logic       w_nmi_fall, w_use_nmi, w_req, w_not_rst;
  kind_t      w_req_kind;

  // A fall seen while in T4 still counts as pending for the vector choice at T5.
  assign w_nmi_fall = r_nmi_s2 & ~r_nmi_s1;
  assign w_use_nmi  = (r_state == S_T4) &&
                      ((r_kind == K_NMI) ||
                       (((r_kind == K_IRQ) || (r_kind == K_BRK)) && (r_nmi_pend || w_nmi_fall)));
  assign w_not_rst  = (r_kind != K_RST);

  always_comb begin
    w_req      = 1'b1;
    w_req_kind = K_BRK;
    if (r_reset_pend)          w_req_kind = K_RST;
    else if (r_nmi_pend)       w_req_kind = K_NMI;
    else if (~_IRQ & ~i_flag)  w_req_kind = K_IRQ;
    else if (!brk_op)          w_req      = 1'b0;
  end

  always_ff @(posedge PHI0 or negedge _RES) begin
    if (!_RES) begin
      r_nmi_s1   <= 1'b1;
      r_nmi_s2   <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_nmi_s1 <= _NMI;
      r_nmi_s2 <= r_nmi_s1;
      if (w_use_nmi)       r_nmi_pend <= 1'b0;
      else if (w_nmi_fall) r_nmi_pend <= 1'b1;
    end
  end

  always_ff @(posedge PHI0 or negedge _RES) begin
    if (!_RES) begin
      r_state          <= S_IDLE;
      r_kind           <= K_RST;
      r_reset_pend     <= 1'b1;
      r_busy           <= 1'b0;
      r_force_brk      <= 1'b0;
      r_pc_inc_inhibit <= 1'b0;
      r_push_pch       <= 1'b0;
      r_push_pcl       <= 1'b0;
      r_push_p         <= 1'b0;
      r_sp_dec         <= 1'b0;
      r_fetch_vec_lo   <= 1'b0;
      r_fetch_vec_hi   <= 1'b0;
      r_set_i          <= 1'b0;
      r_b_flag         <= 1'b0;
      r_int_done       <= 1'b0;
      r_vec_adl        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_int_done <= 1'b0;
          if (sync && w_req) begin
            r_state          <= S_T0;
            r_kind           <= w_req_kind;
            r_force_brk      <= (w_req_kind != K_BRK);
            r_pc_inc_inhibit <= (w_req_kind != K_BRK);
            if (w_req_kind == K_RST) r_reset_pend <= 1'b0;
          end
        end
        S_T0: begin
          r_force_brk <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= S_T1;
        end
        S_T1: if (rdy) begin
          r_pc_inc_inhibit <= 1'b0;
          r_sp_dec         <= 1'b1;
          r_push_pch       <= w_not_rst;
          r_state          <= S_T2;
        end
        S_T2: begin
          r_push_pch <= 1'b0;
          r_push_pcl <= w_not_rst;
          r_state    <= S_T3;
        end
        S_T3: begin
          r_push_pcl <= 1'b0;
          r_push_p   <= w_not_rst;
          r_b_flag   <= (r_kind == K_BRK);
          r_state    <= S_T4;
        end
        S_T4: begin
          r_push_p       <= 1'b0;
          r_b_flag       <= 1'b0;
          r_sp_dec       <= 1'b0;
          r_fetch_vec_lo <= 1'b1;
          r_set_i        <= 1'b1;
          r_vec_adl      <= (r_kind == K_RST) ? 3'b100 : (w_use_nmi ? 3'b010 : 3'b110);
          r_state        <= S_T5;
        end
        S_T5: if (rdy) begin
          r_fetch_vec_lo <= 1'b0;
          r_set_i        <= 1'b0;
          r_fetch_vec_hi <= 1'b1;
          r_vec_adl      <= {r_vec_adl[2:1], 1'b1};
          r_state        <= S_T6;
        end
        S_T6: if (rdy) begin
          r_fetch_vec_hi <= 1'b0;
          r_vec_adl      <= '0;
          r_busy         <= 1'b0;
          r_int_done     <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign force_brk      = r_force_brk;
  assign pc_inc_inhibit = r_pc_inc_inhibit;
  assign push_pch       = r_push_pch;
  assign push_pcl       = r_push_pcl;
  assign push_p         = r_push_p;
  assign sp_dec         = r_sp_dec;
  assign fetch_vec_lo   = r_fetch_vec_lo;
  assign fetch_vec_hi   = r_fetch_vec_hi;
  assign set_i          = r_set_i;
  assign b_flag         = r_b_flag;
  assign int_done       = r_int_done;
  assign vec_adl        = r_vec_adl;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus randomized traffic, each cycle
// compared against a step-counter reference model of the interrupt sequence.
module tb_interrupt_sequencer;

  logic PHI0, res_n, nmi_n, irq_n, iflag, rdy, sync, brk_op;
  logic busy, force_brk, pc_inc_inhibit, push_pch, push_pcl, push_p, sp_dec;
  logic fetch_vec_lo, fetch_vec_hi, set_i, b_flag, int_done;
  logic [2:0]  vec_adl;
  logic [14:0] w_dut;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: step -1 = idle, 0..6 = T0..T6; kind 0 RST, 1 NMI, 2 IRQ, 3 BRK.
  int m_step, m_kind;
  bit m_vec_nmi, m_done, m_rpend, m_npend, m_h1, m_h2;

  interrupt_sequencer dut (
    .PHI0(PHI0), ._RES(res_n), ._NMI(nmi_n), ._IRQ(irq_n), .i_flag(iflag), .rdy(rdy),
    .sync(sync), .brk_op(brk_op), .busy(busy), .force_brk(force_brk),
    .pc_inc_inhibit(pc_inc_inhibit), .push_pch(push_pch), .push_pcl(push_pcl),
    .push_p(push_p), .sp_dec(sp_dec), .fetch_vec_lo(fetch_vec_lo),
    .fetch_vec_hi(fetch_vec_hi), .set_i(set_i), .b_flag(b_flag), .int_done(int_done),
    .vec_adl(vec_adl)
  );

  assign w_dut = {busy, force_brk, pc_inc_inhibit, push_pch, push_pcl, push_p, sp_dec,
                  fetch_vec_lo, fetch_vec_hi, set_i, b_flag, int_done, vec_adl};

  initial PHI0 = 1'b0;
  always #5 PHI0 = ~PHI0;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_step = -1; m_kind = 0; m_vec_nmi = 0; m_done = 0;
    m_rpend = 1; m_npend = 0; m_h1 = 1; m_h2 = 1;
  endtask

  task automatic model_edge();
    bit fall, use_nmi;
    int req;
    fall = m_h2 && !m_h1;
    use_nmi = 0;
    m_done = 0;
    case (m_step)
      -1: if (sync) begin
        req = m_rpend ? 0 : m_npend ? 1 : (!irq_n && !iflag) ? 2 : brk_op ? 3 : -1;
        if (req >= 0) begin
          m_kind = req; m_step = 0;
          if (req == 0) m_rpend = 0;
        end
      end
      0, 2, 3: m_step++;
      1, 5: if (rdy) m_step++;
      4: begin
        use_nmi = (m_kind == 1) || (m_kind >= 2 && (m_npend || fall));
        m_vec_nmi = use_nmi;
        m_step = 5;
      end
      6: if (rdy) begin m_step = -1; m_done = 1; end
      default: m_step = -1;
    endcase
    if (use_nmi) m_npend = 0;
    else if (fall) m_npend = 1;
    m_h2 = m_h1;
    m_h1 = nmi_n;
  endtask

  function automatic logic [14:0] model_out();
    logic [2:0] v;
    v = 3'b000;
    if (m_step == 5 || m_step == 6) begin
      v = (m_kind == 0) ? 3'd4 : (m_vec_nmi ? 3'd2 : 3'd6);
      if (m_step == 6) v[0] = 1'b1;
    end
    return {m_step >= 1, m_step == 0 && m_kind != 3, (m_step == 0 || m_step == 1) && m_kind != 3,
            m_step == 2 && m_kind != 0, m_step == 3 && m_kind != 0, m_step == 4 && m_kind != 0,
            m_step >= 2 && m_step <= 4, m_step == 5, m_step == 6, m_step == 5,
            m_step == 4 && m_kind == 3, m_done, v};
  endfunction

  task automatic tick();
    @(posedge PHI0);
    if (res_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b1;
    #2 res_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (w_dut !== 15'd0) begin n_bad++; $display("FAIL reset_now: got %b want %b", w_dut, 15'd0); end
    sync = 1'b1; irq_n = 1'b0; iflag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (w_dut !== 15'd0) begin n_bad++; $display("FAIL reset_hold c%0d: got %b want %b", c, w_dut, 15'd0); end
    end
    sync = 1'b0; irq_n = 1'b1; iflag = 1'b1;
  endtask

  task automatic test_rst_seq();
    int done_at;
    done_at = -1;
    res_n = 1'b1;
    tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    n_cmp++;
    if (force_brk !== 1'b1) begin n_bad++; $display("FAIL rst_t0_force_brk: got %b want 1", force_brk); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL rst_seq c%0d: got %b want %b", c, w_dut, model_out()); end
      if (int_done && done_at < 0) done_at = c;
      if (c >= 2 && c <= 4) begin
        n_cmp++;
        if ({sp_dec, push_pch, push_pcl, push_p} !== 4'b1000) begin
          n_bad++; $display("FAIL rst_push c%0d: got %b want 1000", c, {sp_dec, push_pch, push_pcl, push_p});
        end
      end
      if (c == 5 || c == 6) begin
        n_cmp++;
        if (vec_adl !== ((c == 5) ? 3'b100 : 3'b101)) begin
          n_bad++; $display("FAIL rst_vec c%0d: got %b want %b", c, vec_adl, (c == 5) ? 3'b100 : 3'b101);
        end
      end
    end
    n_cmp++;
    if (done_at !== 7) begin n_bad++; $display("FAIL rst_latency: got %0d want 7", done_at); end
  endtask

  task automatic test_irq();
    int done_at, starts;
    done_at = -1;
    irq_n = 1'b0; iflag = 1'b0; sync = 1'b1;
    tick();
    sync = 1'b0; irq_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL irq_seq c%0d: got %b want %b", c, w_dut, model_out()); end
      if (int_done && done_at < 0) done_at = c;
      if (c == 4) begin
        n_cmp++;
        if ({push_p, b_flag} !== 2'b10) begin n_bad++; $display("FAIL irq_t4: got %b want 10", {push_p, b_flag}); end
      end
      if (c == 5) begin
        n_cmp++;
        if ({set_i, vec_adl} !== 4'b1110) begin n_bad++; $display("FAIL irq_t5: got %b want 1110", {set_i, vec_adl}); end
      end
      if (c == 6) begin
        n_cmp++;
        if (vec_adl !== 3'b111) begin n_bad++; $display("FAIL irq_t6: got %b want 111", vec_adl); end
      end
    end
    n_cmp++;
    if (done_at !== 7) begin n_bad++; $display("FAIL irq_latency: got %0d want 7", done_at); end
    starts = 0;
    irq_n = 1'b0; iflag = 1'b1; sync = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL irq_masked c%0d: got %b want %b", c, w_dut, model_out()); end
      if (force_brk || busy) starts++;
    end
    n_cmp++;
    if (starts !== 0) begin n_bad++; $display("FAIL irq_masked_starts: got %0d want 0", starts); end
    irq_n = 1'b1; sync = 1'b0;
  endtask

  task automatic test_brk_hijack();
    int starts;
    brk_op = 1'b1; sync = 1'b1;
    tick();
    brk_op = 1'b0; sync = 1'b0;
    n_cmp++;
    if ({force_brk, pc_inc_inhibit} !== 2'b00) begin n_bad++; $display("FAIL brk_t0: got %b want 00", {force_brk, pc_inc_inhibit}); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL brk_seq c%0d: got %b want %b", c, w_dut, model_out()); end
      if (c == 3) nmi_n = 1'b0;
      if (c == 4) begin
        n_cmp++;
        if (b_flag !== 1'b1) begin n_bad++; $display("FAIL brk_bflag: got %b want 1", b_flag); end
      end
      if (c == 5) begin
        n_cmp++;
        if ({vec_adl, dut.r_nmi_pend} !== 4'b0100) begin
          n_bad++; $display("FAIL brk_hijack: got vec=%b pend=%b want vec=010 pend=0", vec_adl, dut.r_nmi_pend);
        end
      end
    end
    starts = 0;
    sync = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL brk_after c%0d: got %b want %b", c, w_dut, model_out()); end
      if (force_brk) starts++;
    end
    n_cmp++;
    if (starts !== 0) begin n_bad++; $display("FAIL brk_nmi_consumed: got %0d starts want 0", starts); end
    sync = 1'b0; nmi_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_nmi_hold();
    int starts;
    bit refired;
    starts = 0;
    nmi_n = 1'b0;
    for (int c = 0; c < 50; c++) begin
      sync = (m_step == -1);
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL nmi_hold c%0d: got %b want %b", c, w_dut, model_out()); end
      if (force_brk) starts++;
    end
    n_cmp++;
    if (starts !== 1) begin n_bad++; $display("FAIL nmi_hold_count: got %0d want 1", starts); end
    nmi_n = 1'b1; sync = 1'b0;
    tick(); tick(); tick();
    nmi_n = 1'b0; starts = 0; refired = 0;
    for (int c = 0; c < 40; c++) begin
      sync = (m_step == -1);
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL nmi_refire c%0d: got %b want %b", c, w_dut, model_out()); end
      if (force_brk) starts++;
      if (m_step == 2) nmi_n = 1'b1;
      if (m_step == 6 && !refired) begin nmi_n = 1'b0; refired = 1; end
    end
    n_cmp++;
    if (starts !== 2) begin n_bad++; $display("FAIL nmi_refire_count: got %0d want 2", starts); end
    nmi_n = 1'b1; sync = 1'b0;
    tick(); tick();
  endtask

  task automatic test_rdy_stall();
    int done_at, lo_cnt, stalls;
    done_at = -1; lo_cnt = 0; stalls = 0;
    irq_n = 1'b0; iflag = 1'b0; sync = 1'b1;
    tick();
    sync = 1'b0; irq_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      rdy = 1'b1;
      if (m_step == 3) rdy = 1'b0;
      if (m_step == 5 && stalls < 3) begin rdy = 1'b0; stalls++; end
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL stall_seq c%0d: got %b want %b", c, w_dut, model_out()); end
      if (fetch_vec_lo) lo_cnt++;
      if (int_done && done_at < 0) done_at = c;
    end
    rdy = 1'b1; iflag = 1'b1;
    n_cmp++;
    if (lo_cnt !== 4) begin n_bad++; $display("FAIL stall_vec_lo: got %0d cycles want 4", lo_cnt); end
    n_cmp++;
    if (done_at !== 10) begin n_bad++; $display("FAIL stall_latency: got %0d want 10", done_at); end
  endtask

  task automatic test_res_mid();
    int rst_vec;
    rst_vec = 0;
    irq_n = 1'b0; iflag = 1'b0; sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    #2 res_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (w_dut !== 15'd0) begin n_bad++; $display("FAIL res_mid_async: got %b want %b", w_dut, 15'd0); end
    tick(); tick();
    n_cmp++;
    if (w_dut !== 15'd0) begin n_bad++; $display("FAIL res_mid_hold: got %b want %b", w_dut, 15'd0); end
    res_n = 1'b1; irq_n = 1'b1; iflag = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sync = (m_step == -1);
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL res_mid_seq c%0d: got %b want %b", c, w_dut, model_out()); end
      if (vec_adl === 3'b100) rst_vec++;
    end
    sync = 1'b0;
    n_cmp++;
    if (rst_vec !== 1) begin n_bad++; $display("FAIL res_mid_rst_vec: got %0d want 1", rst_vec); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      res_n = ($urandom_range(0, 79) != 0);
      if (!res_n) model_reset();
      if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
      irq_n  = ($urandom_range(0, 3) != 0);
      iflag  = $urandom_range(0, 1);
      rdy    = ($urandom_range(0, 3) != 0);
      sync   = $urandom_range(0, 1);
      brk_op = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (w_dut !== model_out()) begin n_bad++; $display("FAIL random i%0d: got %b want %b", i, w_dut, model_out()); end
    end
    res_n = 1'b1; rdy = 1'b1; sync = 1'b0; nmi_n = 1'b1; irq_n = 1'b1;
  endtask

  initial begin
    res_n = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; iflag = 1'b1;
    rdy = 1'b1; sync = 1'b0; brk_op = 1'b0;
    model_reset();
    test_reset();
    test_rst_seq();
    test_irq();
    test_brk_hijack();
    test_nmi_hold();
    test_rdy_stall();
    test_res_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
